output_pack_store: RTL

OUTPUT_PACK_STORE -- requirements
Module: output_pack_store

---
 rtl/output_pack_store.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/output_pack_store.sv
// rtl/output_pack_store.sv - packs an 8-bit pixel stream into 128-bit memory words for one frame
//
// Purpose: accepts one byte per ValidIn cycle, fills lanes 0..15 of a word,
// and writes each completed word to base + word_cnt. It stops after
// WORDS_PER_FRAME words and flags any bytes that arrive after that.
//
// Ports:
//   clock         rising-edge clock
//   reset_n       asynchronous active-low reset
//   start         frame enable (high = run, low = abort / idle)
//   base_sel      frame base select; base = {base_sel, 15'b0}; sampled in IDLE
//   DataIn        pixel byte
//   ValidIn       DataIn qualifier
//   WriteBus      packed 128-bit word (holds when no write)
//   WriteAddress  word address (holds when no write)
//   WriteEnable   one-cycle write strobe
//   FrameDone     last word written; held until start drops
//   Overrun       sticky: byte presented after the frame completed

module output_pack_store #(
  parameter int WORDS_PER_FRAME = 19200
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic         base_sel,
  input  logic [7:0]   DataIn,
  input  logic         ValidIn,
  output logic [127:0] WriteBus,
  output logic [15:0]  WriteAddress,
  output logic         WriteEnable,
  output logic         FrameDone,
  output logic         Overrun
);

  localparam logic [14:0] LAST_WORD = 15'(WORDS_PER_FRAME - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PACK = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_base;
  logic           w_base_nxt;
  logic [3:0]     r_byte_idx;
  logic [3:0]     w_byte_idx_nxt;
  logic [14:0]    r_word_cnt;
  logic [14:0]    w_word_cnt_nxt;
  logic [127:0]   r_word_buf;
  logic [127:0]   w_word_buf_nxt;
  logic [127:0]   w_bus_nxt;
  logic [15:0]    w_addr_nxt;
  logic           w_we_nxt;
  logic           w_done_nxt;
  logic           w_ovr_nxt;

  always_comb begin
    w_state_nxt    = r_state;
    w_base_nxt     = r_base;
    w_byte_idx_nxt = r_byte_idx;
    w_word_cnt_nxt = r_word_cnt;
    w_word_buf_nxt = r_word_buf;
    w_bus_nxt      = WriteBus;
    w_addr_nxt     = WriteAddress;
    w_we_nxt       = 1'b0;
    w_done_nxt     = FrameDone;
    w_ovr_nxt      = Overrun;

    if (!start) begin
      // Abort takes priority over everything, including a completing 16th byte.
      w_state_nxt    = S_IDLE;
      w_byte_idx_nxt = 4'd0;
      w_word_cnt_nxt = 15'd0;
      w_done_nxt     = 1'b0;
      w_ovr_nxt      = 1'b0;
      if (r_state == S_IDLE) begin
        w_base_nxt = base_sel;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          // ValidIn is deliberately ignored in the cycle start rises.
          w_base_nxt     = base_sel;
          w_byte_idx_nxt = 4'd0;
          w_word_cnt_nxt = 15'd0;
          w_done_nxt     = 1'b0;
          w_ovr_nxt      = 1'b0;
          w_state_nxt    = S_PACK;
        end
        S_PACK: begin
          if (ValidIn) begin
            w_word_buf_nxt[{r_byte_idx, 3'b000} +: 8] = DataIn;
            w_byte_idx_nxt = r_byte_idx + 4'd1;
            if (r_byte_idx == 4'd15) begin
              // Word is written straight from the merged buffer so the
              // last byte needs no extra cycle.
              w_bus_nxt      = w_word_buf_nxt;
              w_addr_nxt     = {r_base, 15'b0} + {1'b0, r_word_cnt};
              w_we_nxt       = 1'b1;
              w_word_cnt_nxt = r_word_cnt + 15'd1;
              if (r_word_cnt == LAST_WORD) begin
                w_state_nxt = S_DONE;
                w_done_nxt  = 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          if (ValidIn) begin
            w_ovr_nxt = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_base       <= 1'b0;
      r_byte_idx   <= 4'd0;
      r_word_cnt   <= 15'd0;
      r_word_buf   <= 128'h0;
      WriteBus     <= 128'h0;
      WriteAddress <= 16'h0;
      WriteEnable  <= 1'b0;
      FrameDone    <= 1'b0;
      Overrun      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_base       <= w_base_nxt;
      r_byte_idx   <= w_byte_idx_nxt;
      r_word_cnt   <= w_word_cnt_nxt;
      r_word_buf   <= w_word_buf_nxt;
      WriteBus     <= w_bus_nxt;
      WriteAddress <= w_addr_nxt;
      WriteEnable  <= w_we_nxt;
      FrameDone    <= w_done_nxt;
      Overrun      <= w_ovr_nxt;
    end
  end

endmodule
